// File: rtl/cp0_exception_ctrl.sv
// cp0_exception_ctrl
//   Sequences the CP0 register updates for exception entry, interrupt entry
//   and ERET. An event accepted in IDLE produces one ENTER cycle, in which the
//   CP0 write strobes, flush and PC redirect are asserted. It is followed by
//   one DRAIN cycle, in which only flush and busy are asserted. The global
//   ready input freezes the whole controller.
//
// Ports
//   clock, reset            clock and asynchronous active-low reset
//   ready                   global advance; 0 holds state, ip_q and outputs
//   mem_valid, mem_pc       memory-stage instruction and its PC
//   mem_in_delay            instruction sits in a branch delay slot
//   exc_valid, exc_code     exception report and MIPS ExcCode
//   exc_badaddr             faulting address (used for AdEL/AdES)
//   eret_valid              instruction is ERET
//   hw_int                  hardware interrupt lines (sticky-latched)
//   status_in .. ebase_in   bypassed CP0 register values
//   writeN / writeNdata     one-cycle strobes and data for BadVAddr(8),
//                           Status(12), Cause(13) and EPC(14)
//   flush                   squash younger pipeline stages
//   redirect_valid/_pc      PC redirect request and target
//   busy                    controller is not IDLE
module cp0_exception_ctrl #(
    parameter logic [31:0] VEC_OFFSET = 32'h180,
    parameter int          INT_W      = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ready,
    input  logic             mem_valid,
    input  logic [31:0]      mem_pc,
    input  logic             mem_in_delay,
    input  logic             exc_valid,
    input  logic [4:0]       exc_code,
    input  logic [31:0]      exc_badaddr,
    input  logic             eret_valid,
    input  logic [INT_W-1:0] hw_int,
    input  logic [31:0]      status_in,
    input  logic [31:0]      cause_in,
    input  logic [31:0]      epc_in,
    input  logic [31:0]      ebase_in,
    output logic             write8,
    output logic [31:0]      write8data,
    output logic             write12,
    output logic [31:0]      write12data,
    output logic             write13,
    output logic [31:0]      write13data,
    output logic             write14,
    output logic [31:0]      write14data,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTER = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [INT_W-1:0]   ip_q, ip_nxt;

    logic               int_take, exc_take, eret_take, accept;
    logic [31:0]        vector_pc;

    logic               write8_nxt, write12_nxt, write13_nxt, write14_nxt;
    logic [31:0]        write8data_nxt, write12data_nxt, write13data_nxt, write14data_nxt;
    logic               flush_nxt, redirect_valid_nxt, busy_nxt;
    logic [31:0]        redirect_pc_nxt;

    // The vector base keeps only the 4 KiB-aligned part of EBase.
    logic               unused_ebase_low;
    assign unused_ebase_low = ^ebase_in[11:0];

    // EPC points at the branch when the faulting instruction is in its delay slot.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic in_delay);
        return in_delay ? (pc - 32'd4) : pc;
    endfunction

    function automatic logic [31:0] cause_merge(input logic [31:0]      cause,
                                                input logic             bd,
                                                input logic [INT_W-1:0] ip,
                                                input logic [4:0]       code);
        logic [31:0] c;
        c              = cause;
        c[31]          = bd;
        c[10 +: INT_W] = ip;
        c[6:2]         = code;
        return c;
    endfunction

    always_comb begin
        int_take  = mem_valid & status_in[0] & ~status_in[1]
                  & (|(ip_q & status_in[10 +: INT_W]));
        exc_take  = ~int_take & mem_valid & exc_valid;
        eret_take = ~int_take & ~exc_take & mem_valid & eret_valid;
        accept    = (state == IDLE) & (int_take | exc_take | eret_take);
        vector_pc = {ebase_in[31:12], 12'h000} + VEC_OFFSET;
    end

    // Pending bits recorded into Cause are cleared on interrupt entry; a line
    // that is high on the same edge re-sets its bit.
    always_comb begin
        ip_nxt = ip_q;
        if (accept && int_take) begin
            ip_nxt = '0;
        end
        ip_nxt = ip_nxt | hw_int;
    end

    always_comb begin
        state_nxt          = state;
        write8_nxt         = write8;
        write8data_nxt     = write8data;
        write12_nxt        = write12;
        write12data_nxt    = write12data;
        write13_nxt        = write13;
        write13data_nxt    = write13data;
        write14_nxt        = write14;
        write14data_nxt    = write14data;
        flush_nxt          = flush;
        redirect_valid_nxt = redirect_valid;
        redirect_pc_nxt    = redirect_pc;
        busy_nxt           = busy;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt          = ENTER;
                    flush_nxt          = 1'b1;
                    redirect_valid_nxt = 1'b1;
                    busy_nxt           = 1'b1;
                    write12_nxt        = 1'b1;
                    if (eret_take) begin
                        write8_nxt      = 1'b0;
                        write13_nxt     = 1'b0;
                        write14_nxt     = 1'b0;
                        write12data_nxt = status_in & ~32'h2;
                        redirect_pc_nxt = epc_in;
                    end else begin
                        write12data_nxt = status_in | 32'h2;
                        write13_nxt     = 1'b1;
                        write13data_nxt = cause_merge(cause_in, mem_in_delay, ip_q,
                                                      int_take ? 5'd0 : exc_code);
                        // With EXL already set the original EPC must survive.
                        write14_nxt     = ~status_in[1];
                        write14data_nxt = epc_of(mem_pc, mem_in_delay);
                        write8_nxt      = exc_take & ((exc_code == 5'd4) | (exc_code == 5'd5));
                        write8data_nxt  = exc_badaddr;
                        redirect_pc_nxt = vector_pc;
                    end
                end
            end
            ENTER: begin
                state_nxt          = DRAIN;
                write8_nxt         = 1'b0;
                write12_nxt        = 1'b0;
                write13_nxt        = 1'b0;
                write14_nxt        = 1'b0;
                redirect_valid_nxt = 1'b0;
                flush_nxt          = 1'b1;
                busy_nxt           = 1'b1;
            end
            DRAIN: begin
                state_nxt = IDLE;
                flush_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt          = IDLE;
                write8_nxt         = 1'b0;
                write12_nxt        = 1'b0;
                write13_nxt        = 1'b0;
                write14_nxt        = 1'b0;
                redirect_valid_nxt = 1'b0;
                flush_nxt          = 1'b0;
                busy_nxt           = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            ip_q           <= '0;
            write8         <= 1'b0;
            write8data     <= '0;
            write12        <= 1'b0;
            write12data    <= '0;
            write13        <= 1'b0;
            write13data    <= '0;
            write14        <= 1'b0;
            write14data    <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            busy           <= 1'b0;
        end else if (ready) begin
            state          <= state_nxt;
            ip_q           <= ip_nxt;
            write8         <= write8_nxt;
            write8data     <= write8data_nxt;
            write12        <= write12_nxt;
            write12data    <= write12data_nxt;
            write13        <= write13_nxt;
            write13data    <= write13data_nxt;
            write14        <= write14_nxt;
            write14data    <= write14data_nxt;
            flush          <= flush_nxt;
            redirect_valid <= redirect_valid_nxt;
            redirect_pc    <= redirect_pc_nxt;
            busy           <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
module tb_cp0_exception_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        ready;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_in_delay;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_badaddr;
    logic        eret_valid;
    logic [5:0]  hw_int;
    logic [31:0] status_in, cause_in, epc_in, ebase_in;
    logic        write8, write12, write13, write14;
    logic [31:0] write8data, write12data, write13data, write14data;
    logic        flush, redirect_valid, busy;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] VEC = 32'h9FC0_0180;

    cp0_exception_ctrl #(.VEC_OFFSET(32'h180), .INT_W(6)) dut (
        .clock(clock), .reset(reset), .ready(ready),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_in_delay(mem_in_delay),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_badaddr(exc_badaddr),
        .eret_valid(eret_valid), .hw_int(hw_int),
        .status_in(status_in), .cause_in(cause_in), .epc_in(epc_in), .ebase_in(ebase_in),
        .write8(write8), .write8data(write8data),
        .write12(write12), .write12data(write12data),
        .write13(write13), .write13data(write13data),
        .write14(write14), .write14data(write14data),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Outputs launched by an edge are sampled 1 time unit after it; inputs
    // changed at that point are taken by the following edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_events();
        mem_valid    = 1'b0;
        exc_valid    = 1'b0;
        eret_valid   = 1'b0;
        mem_in_delay = 1'b0;
        hw_int       = '0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".strobes"}, {28'h0, write8, write12, write13, write14}, 32'h0);
        chk({tag, ".ctl"}, {29'h0, flush, redirect_valid, busy}, 32'h0);
    endtask

    initial begin
        reset = 1'b0; ready = 1'b1;
        clear_events();
        mem_pc = '0; exc_code = '0; exc_badaddr = '0;
        status_in = '0; cause_in = 32'h4000_0000; epc_in = '0; ebase_in = 32'h9FC0_0ABC;
        step(); step();
        chk_quiet("reset");
        chk("reset.redirect_pc", redirect_pc, 32'h0);
        reset = 1'b1;

        // Interrupt entry
        status_in = 32'h0000_0401;
        hw_int = 6'b000001;
        step();
        hw_int = '0; mem_valid = 1'b1; mem_pc = 32'h8000_1000;
        step();
        chk("int.strobes", {28'h0, write8, write12, write13, write14}, 32'h7);
        chk("int.cause", write13data, 32'h4000_0400);
        chk("int.epc", write14data, 32'h8000_1000);
        chk("int.status", write12data, 32'h0000_0403);
        chk("int.redirect_pc", redirect_pc, VEC);
        chk("int.ctl", {29'h0, flush, redirect_valid, busy}, 32'h7);
        mem_valid = 1'b0;
        step();
        chk("int.drain", {28'h0, write13, flush, redirect_valid, busy}, 32'h5);
        step();
        chk_quiet("int.idle");
        // Pending bit must be gone: the same conditions no longer trigger.
        mem_valid = 1'b1;
        step();
        chk("int.ip_cleared", {31'h0, busy}, 32'h0);
        clear_events();

        // Address-error exception in a delay slot, EXL clear
        cause_in = 32'h0;
        status_in = 32'h0000_0400;
        mem_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'd4;
        exc_badaddr = 32'h0000_0003; mem_in_delay = 1'b1; mem_pc = 32'h8000_0204;
        step();
        clear_events();
        chk("exc.strobes", {28'h0, write8, write12, write13, write14}, 32'hF);
        chk("exc.badaddr", write8data, 32'h0000_0003);
        chk("exc.epc", write14data, 32'h8000_0200);
        chk("exc.cause", write13data, 32'h8000_0010);
        chk("exc.status", write12data, 32'h0000_0402);
        chk("exc.flush1", {31'h0, flush}, 32'h1);
        step();
        chk("exc.flush2", {31'h0, flush}, 32'h1);
        step();
        chk("exc.flush3", {31'h0, flush}, 32'h0);

        // Same exception with EXL already set: EPC untouched
        status_in = 32'h0000_0402;
        mem_valid = 1'b1; exc_valid = 1'b1; mem_in_delay = 1'b1;
        step();
        clear_events();
        chk("exl.strobes", {28'h0, write8, write12, write13, write14}, 32'hE);
        chk("exl.redirect", {redirect_valid, redirect_pc[30:0]}, {1'b1, VEC[30:0]});
        step(); step();

        // ERET
        status_in = 32'h0000_0003; epc_in = 32'h8000_2000;
        mem_valid = 1'b1; eret_valid = 1'b1;
        step();
        clear_events();
        chk("eret.strobes", {28'h0, write8, write12, write13, write14}, 32'h4);
        chk("eret.status", write12data, 32'h0000_0001);
        chk("eret.redirect_pc", redirect_pc, 32'h8000_2000);
        chk("eret.rv", {31'h0, redirect_valid}, 32'h1);
        step(); step();

        // Exception + ERET together, then stall during ENTER
        status_in = 32'h0000_0400;
        mem_valid = 1'b1; exc_valid = 1'b1; eret_valid = 1'b1;
        exc_code = 5'd5; exc_badaddr = 32'h0000_1234; mem_pc = 32'h8000_3000;
        step();
        clear_events();
        chk("both.cause", write13data, 32'h0000_0014);
        chk("both.badaddr", write8data, 32'h0000_1234);
        ready = 1'b0;
        hw_int = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stall%0d.strobes", i), {28'h0, write8, write12, write13, write14}, 32'hF);
            chk($sformatf("stall%0d.ctl", i), {29'h0, flush, redirect_valid, busy}, 32'h7);
        end
        ready = 1'b1;
        hw_int = '0;
        step();
        chk("stall.drain", {28'h0, write13, flush, redirect_valid, busy}, 32'h5);
        mem_valid = 1'b1; exc_valid = 1'b1;
        step();
        clear_events();
        chk_quiet("stall.idle");
        step();
        chk("drain_exc_ignored", {31'h0, busy}, 32'h0);
        // hw_int seen only while stalled must not have been latched.
        status_in = 32'h0000_0401; mem_valid = 1'b1;
        step();
        clear_events();
        chk("stall.no_latch", {31'h0, busy}, 32'h0);

        // A line high on the take edge survives the clear
        hw_int = 6'b000001;
        step();
        mem_valid = 1'b1;
        step();
        hw_int = '0; mem_valid = 1'b0;
        chk("resurv.cause", write13data, 32'h0000_0400);
        step(); step();
        mem_valid = 1'b1;
        step();
        clear_events();
        chk("resurv.retake", {31'h0, busy}, 32'h1);
        step(); step();

        // Asynchronous reset in the middle of ENTER
        status_in = 32'h0000_0400;
        mem_valid = 1'b1; exc_valid = 1'b1; exc_code = 5'd4; hw_int = 6'b000001;
        step();
        clear_events();
        chk("rst.pre_busy", {31'h0, busy}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk_quiet("rst.async");
        step();
        reset = 1'b1;
        status_in = 32'h0000_0401; mem_valid = 1'b1;
        step();
        clear_events();
        chk("rst.ip_cleared", {31'h0, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
